i2s_rx_deserializer: RTL and testbench
======================================

Name: i2s_rx_deserializer

Overview:
- Serial audio front end directly upstream of the SRAM sample cacher.
- Synchronises the selected BCK/LRCK/SData stream (PCM1802 or CS8416, both in I2S mode) into the system Clock domain.
- Deserialises stereo slots and presents a 16-bit left/right pair with a one-cycle strobe for the cacher.
- Flags full-scale samples and malformed slots for the Spectolizer status logic.

Parameters:
- SLOT_BITS, 24, maximum data bits captured per channel slot; extra BCKs are ignored.
- OUT_BITS, 16, MSB-aligned output width; must satisfy OUT_BITS <= SLOT_BITS.
- SYNC_STAGES, 3, flip-flop depth of the input synchronisers; minimum 2.

Ports:
- Clock  input  1  system clock, 67.8 MHz.
- Reset  input  1  synchronous, active-low reset.
- BCK  input  1  asynchronous bit clock, at most 64fs at 96 kHz.
- LRCK  input  1  asynchronous word clock; 0 = left, 1 = right.
- SData  input  1  asynchronous serial data, MSB first.
- SampleL  output  OUT_BITS  left sample, two's complement.
- SampleR  output  OUT_BITS  right sample, two's complement.
- Valid  output  1  one-Clock strobe; SampleL/SampleR are new this cycle.
- Clip  output  1  sticky-per-pair flag: either output sample is 16'h7FFF or 16'h8000 (valid with Valid).
- SlotErr  output  1  one-Clock pulse: a slot ended with fewer than OUT_BITS bits.

Behaviour:
- Reset (Reset==0 at a Clock edge):
  - All outputs go to 0.
  - Synchroniser chains, shift register, bit counter and held left word are cleared.
  - State goes to HUNT.
- Input synchronisation and sampling:
  - BCK, LRCK and SData each pass through SYNC_STAGES flip-flops.
  - A BCK rising event is detected from the last two BCK stages.
  - All deserialiser actions occur only on Clock cycles carrying a BCK rising event.
  - LRCK and SData are taken from the final synchroniser stage in that same cycle.
- State machine (HUNT, WAIT_MSB, SHIFT):
  - HUNT: waits for an LRCK level change between consecutive BCK rises. On a change it goes to WAIT_MSB, records the new channel in lr_cur and sets bitcnt=0. No output is produced while in HUNT.
  - WAIT_MSB: implements the I2S one-BCK delay. The next BCK rise is the MSB: shift it in, set bitcnt=1, go to SHIFT.
  - SHIFT, no LRCK change: if bitcnt<SLOT_BITS, shift SData in and increment bitcnt; otherwise ignore the bit. bitcnt saturates at SLOT_BITS.
  - SHIFT, LRCK change (slot end): close the current slot, then go to WAIT_MSB for the new channel. Closing works as follows:
    - The captured word is the first OUT_BITS shifted-in bits (MSB aligned; lower bits discarded).
    - If bitcnt<OUT_BITS: pulse SlotErr and drop any held left word.
    - Else, if the closed slot is left: hold the word as Lpend and set lvalid.
    - Else (right slot): if lvalid, register SampleL=Lpend and SampleR=word, pulse Valid and compute Clip; then clear lvalid.
    - A right slot without lvalid (first after reset or after an error) is discarded silently.
- Latency: Valid asserts on the Clock edge after the BCK-rise cycle that observes LRCK going 1->0. Total from the pin edge is SYNC_STAGES+1 Clock cycles.
- Outputs hold their values between Valid strobes.
- Valid and SlotErr are never asserted together. SlotErr takes precedence and suppresses Valid.
- Rate change (48k <-> 96k): no special handling. Slot framing re-locks at the next LRCK edge.
- BCK stopped: no strobes are produced and outputs hold. No timeout.

Optional Feature:
- Macro: I2S_RX_LEFT_JUSTIFIED_EN.
- Defined: left-justified format. WAIT_MSB is bypassed: the BCK rise that detects the LRCK change shifts in the MSB of the new slot, after the previous slot is closed. Valid latency is unchanged.
- Undefined: standard I2S one-bit delay, as described above.

Decomposition:
- Shared package (i2s_pkg):
  - State encoding localparams: HUNT=2'd0, WAIT_MSB=2'd1, SHIFT=2'd2.
  - Full-scale constants FS_POS=16'h7FFF and FS_NEG=16'h8000.
  - Channel constants CH_LEFT=1'b0 and CH_RIGHT=1'b1.
- One sub-module: i2s_input_sync, instantiated three times. It contains the SYNC_STAGES chain and, for BCK, the rising-edge detect.

Test Plan:
- I2S at 48 kHz, 64fs BCK. Send L=24'h123456, R=24'hABCDEF -> one Valid with SampleL=16'h1234, SampleR=16'hABCD, Clip=0.
- Send L=24'h7FFF00, R=24'h000000 -> Valid with Clip=1. Then L=0, R=24'h800000 -> Valid with Clip=1.
- Truncated slot: 8 BCKs in a left slot, then a normal right slot -> SlotErr pulses once and no Valid for that pair. The next full pair gives a correct Valid.
- Reset driven low mid-right-slot for 2 Clocks -> all outputs 0. The first partial pair is discarded, and Valid resumes on the second complete L/R pair.
- Switch to 96 kHz with 64fs BCK, and separately a 32fs BCK (16-bit slots) -> correct samples with no SlotErr. Measure Valid latency as SYNC_STAGES+1 Clocks after LRCK falls.
- With I2S_RX_LEFT_JUSTIFIED_EN defined: send a left-justified stream with L=16'h8001, R=16'h0001 -> SampleL=16'h8001, SampleR=16'h0001.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive front end: receiver state
// encoding, full-scale sample constants and LRCK channel values.
package i2s_pkg;

  localparam logic [1:0] HUNT     = 2'd0;
  localparam logic [1:0] WAIT_MSB = 2'd1;
  localparam logic [1:0] SHIFT    = 2'd2;

  typedef enum logic [1:0] {
    StHunt    = HUNT,
    StWaitMsb = WAIT_MSB,
    StShift   = SHIFT
  } rxState_e;

  localparam logic [15:0] FS_POS = 16'h7FFF;
  localparam logic [15:0] FS_NEG = 16'h8000;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_input_sync.sv
// Multi-flop synchroniser for one asynchronous serial-audio pin. It also
// produces a single-cycle rising-edge pulse built from the final stage and
// a delayed copy of it; the receiver only uses that pulse for BCK.
module i2s_input_sync #(
  parameter int STAGES = 3
) (
  input  logic Clock,
  input  logic Reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  // Shift the pin through the synchroniser and keep last cycle's output.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S receive deserialiser: synchronises BCK/LRCK/SData into the system
// clock domain, captures stereo slots MSB first and presents an MSB-aligned
// left/right pair with a one-cycle Valid strobe, a Clip flag and a SlotErr
// pulse for short slots.
// Optional build macro I2S_RX_LEFT_JUSTIFIED_EN selects left-justified
// framing (MSB on the same BCK as the LRCK change) instead of standard I2S.
module i2s_rx_deserializer
  import i2s_pkg::*;
#(
  parameter int SLOT_BITS   = 24,
  parameter int OUT_BITS    = 16,
  parameter int SYNC_STAGES = 3
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                BCK,
  input  logic                LRCK,
  input  logic                SData,
  output logic [OUT_BITS-1:0] SampleL,
  output logic [OUT_BITS-1:0] SampleR,
  output logic                Valid,
  output logic                Clip,
  output logic                SlotErr
);

  localparam int CNT_W = $clog2(SLOT_BITS + 1);
  localparam logic [CNT_W-1:0]     SlotBitsC = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0]     OutBitsC  = CNT_W'(OUT_BITS);
  localparam logic [CNT_W-1:0]     OneC      = CNT_W'(1);
  localparam logic [SLOT_BITS-1:0] MsbMask   = {1'b1, {(SLOT_BITS-1){1'b0}}};
  localparam logic [OUT_BITS-1:0]  FullPos   = {1'b0, {(OUT_BITS-1){1'b1}}};
  localparam logic [OUT_BITS-1:0]  FullNeg   = {1'b1, {(OUT_BITS-1){1'b0}}};

  logic bckRise;
  logic lrckSync;
  logic sdataSync;
  logic unusedBckLevel;
  logic unusedLrckRise;
  logic unusedSdataRise;

  i2s_input_sync #(.STAGES(SYNC_STAGES)) uBckSync (
    .Clock   (Clock),
    .Reset   (Reset),
    .async_i (BCK),
    .sync_o  (unusedBckLevel),
    .rise_o  (bckRise)
  );

  i2s_input_sync #(.STAGES(SYNC_STAGES)) uLrckSync (
    .Clock   (Clock),
    .Reset   (Reset),
    .async_i (LRCK),
    .sync_o  (lrckSync),
    .rise_o  (unusedLrckRise)
  );

  i2s_input_sync #(.STAGES(SYNC_STAGES)) uSdataSync (
    .Clock   (Clock),
    .Reset   (Reset),
    .async_i (SData),
    .sync_o  (sdataSync),
    .rise_o  (unusedSdataRise)
  );

  rxState_e              state_q,   state_d;
  logic                  lrCur_q,   lrCur_d;
  logic                  primed_q,  primed_d;
  logic [CNT_W-1:0]      bitCnt_q,  bitCnt_d;
  logic [SLOT_BITS-1:0]  shReg_q,   shReg_d;
  logic [OUT_BITS-1:0]   lPend_q,   lPend_d;
  logic                  lValid_q,  lValid_d;
  logic [OUT_BITS-1:0]   sampleL_q, sampleL_d;
  logic [OUT_BITS-1:0]   sampleR_q, sampleR_d;
  logic                  valid_q,   valid_d;
  logic                  clip_q,    clip_d;
  logic                  slotErr_q, slotErr_d;

  logic [SLOT_BITS-1:0]  bitMask;
  logic                  lrChange;
  logic [SLOT_BITS-1:0]  closeReg;
  logic [CNT_W-1:0]      closeCnt;
  logic [OUT_BITS-1:0]   closeWord;
  logic                  startSlot;

  // What the current slot would look like if it were closed on this BCK.
  // In I2S the BCK carrying the LRCK change still holds the LSB of the
  // slot being closed, so it is folded in; in left-justified framing that
  // bit already belongs to the new slot.
  always_comb begin
    bitMask  = MsbMask >> bitCnt_q;
    lrChange = (lrckSync != lrCur_q);
    closeReg = shReg_q;
    closeCnt = bitCnt_q;
`ifndef I2S_RX_LEFT_JUSTIFIED_EN
    if (bitCnt_q < SlotBitsC) begin
      closeReg = shReg_q | (sdataSync ? bitMask : '0);
      closeCnt = bitCnt_q + 1'b1;
    end
`endif
    closeWord = closeReg[SLOT_BITS-1 -: OUT_BITS];
  end

  // Framing state machine: hunt for an LRCK edge, capture each slot and
  // pair a held left word with the following right word.
  always_comb begin
    state_d   = state_q;
    lrCur_d   = lrCur_q;
    primed_d  = primed_q;
    bitCnt_d  = bitCnt_q;
    shReg_d   = shReg_q;
    lPend_d   = lPend_q;
    lValid_d  = lValid_q;
    sampleL_d = sampleL_q;
    sampleR_d = sampleR_q;
    clip_d    = clip_q;
    valid_d   = 1'b0;
    slotErr_d = 1'b0;
    startSlot = 1'b0;

    if (bckRise) begin
      case (state_q)
        StHunt: begin
          primed_d = 1'b1;
          lrCur_d  = lrckSync;
          if (primed_q && lrChange) begin
            startSlot = 1'b1;
          end
        end

        StWaitMsb: begin
          if (lrChange) begin
            slotErr_d = 1'b1;
            lValid_d  = 1'b0;
            startSlot = 1'b1;
          end else begin
            shReg_d  = MsbMask & {SLOT_BITS{sdataSync}};
            bitCnt_d = OneC;
            state_d  = StShift;
          end
        end

        StShift: begin
          if (!lrChange) begin
            if (bitCnt_q < SlotBitsC) begin
              shReg_d  = shReg_q | (sdataSync ? bitMask : '0);
              bitCnt_d = bitCnt_q + 1'b1;
            end
          end else begin
            startSlot = 1'b1;
            if (closeCnt < OutBitsC) begin
              slotErr_d = 1'b1;
              lValid_d  = 1'b0;
            end else if (lrCur_q == CH_LEFT) begin
              lPend_d  = closeWord;
              lValid_d = 1'b1;
            end else begin
              if (lValid_q) begin
                sampleL_d = lPend_q;
                sampleR_d = closeWord;
                valid_d   = 1'b1;
                clip_d    = (lPend_q == FullPos) || (lPend_q == FullNeg) ||
                            (closeWord == FullPos) || (closeWord == FullNeg);
              end
              lValid_d = 1'b0;
            end
          end
        end

        default: begin
          state_d = StHunt;
        end
      endcase

      if (startSlot) begin
        lrCur_d = lrckSync;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
        shReg_d  = MsbMask & {SLOT_BITS{sdataSync}};
        bitCnt_d = OneC;
        state_d  = StShift;
`else
        shReg_d  = '0;
        bitCnt_d = '0;
        state_d  = StWaitMsb;
`endif
      end
    end
  end

  // Register all framing state and the output pair.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= StHunt;
      lrCur_q   <= CH_LEFT;
      primed_q  <= 1'b0;
      bitCnt_q  <= '0;
      shReg_q   <= '0;
      lPend_q   <= '0;
      lValid_q  <= 1'b0;
      sampleL_q <= '0;
      sampleR_q <= '0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      slotErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lrCur_q   <= lrCur_d;
      primed_q  <= primed_d;
      bitCnt_q  <= bitCnt_d;
      shReg_q   <= shReg_d;
      lPend_q   <= lPend_d;
      lValid_q  <= lValid_d;
      sampleL_q <= sampleL_d;
      sampleR_q <= sampleR_d;
      valid_q   <= valid_d;
      clip_q    <= clip_d;
      slotErr_q <= slotErr_d;
    end
  end

  assign SampleL = sampleL_q;
  assign SampleR = sampleR_q;
  assign Valid   = valid_q;
  assign Clip    = clip_q;
  assign SlotErr = slotErr_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Testbench for i2s_rx_deserializer. Streams stereo slots bit by bit and
// predicts the expected sample pairs and slot errors from slot-level rules.
// Define I2S_RX_LEFT_JUSTIFIED_EN to exercise left-justified framing.
`timescale 1ns/1ps
module tb_i2s_rx_deserializer;
  import i2s_pkg::*;

  localparam int SLOT_BITS   = 24;
  localparam int OUT_BITS    = 16;
  localparam int SYNC_STAGES = 3;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic BCK   = 1'b0;
  logic LRCK  = 1'b1;
  logic SData = 1'b0;
  logic [OUT_BITS-1:0] SampleL;
  logic [OUT_BITS-1:0] SampleR;
  logic Valid;
  logic Clip;
  logic SlotErr;

  i2s_rx_deserializer #(
    .SLOT_BITS   (SLOT_BITS),
    .OUT_BITS    (OUT_BITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .BCK     (BCK),
    .LRCK    (LRCK),
    .SData   (SData),
    .SampleL (SampleL),
    .SampleR (SampleR),
    .Valid   (Valid),
    .Clip    (Clip),
    .SlotErr (SlotErr)
  );

  // ~67 MHz system clock
  always #7.5 Clock = ~Clock;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        clip;
  } pair_t;

  pair_t expQ[$];
  pair_t obsQ[$];
  int expErr = 0;
  int obsErr = 0;
  int bothCnt = 0;
  int assertCnt = 0;
  int failCnt = 0;
  int cycleCnt = 0;
  int riseCycle = 0;
  int validCycle = 0;
  int halfPer = 11;
  logic pendingBit = 1'b0;

  bit          mdlHunting = 1'b1;
  bit          mdlPrimed  = 1'b0;
  logic        mdlLastCh  = 1'b0;
  bit          mdlLValid  = 1'b0;
  logic [15:0] mdlLPend   = '0;
  logic        prevCh     = 1'b0;
  logic [23:0] prevW      = '0;
  int          prevLen    = 0;

  // Free-running cycle counter used for latency measurement.
  always @(posedge Clock) cycleCnt <= cycleCnt + 1;

  // Collect every strobe the receiver produces, away from the active edge.
  always @(negedge Clock) begin
    if (Reset) begin
      if (Valid) begin
        obsQ.push_back('{SampleL, SampleR, Clip});
        validCycle = cycleCnt;
      end
      if (SlotErr) obsErr++;
      if (Valid && SlotErr) bothCnt++;
    end
  end

  function automatic logic bitOf(input logic [23:0] w, input int k);
    if (k >= 0 && k < 24) return w[23-k];
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slot-level reference: a closed slot either errors, becomes the held
  // left word, or completes a pair with the held left word.
  task automatic modelClose(input logic ch, input logic [23:0] w, input int len);
    pair_t e;
    if (len < OUT_BITS) begin
      expErr++;
      mdlLValid = 1'b0;
    end else if (ch == CH_LEFT) begin
      mdlLPend  = w[23:8];
      mdlLValid = 1'b1;
    end else begin
      if (mdlLValid) begin
        e.l    = mdlLPend;
        e.r    = w[23:8];
        e.clip = (e.l == FS_POS) || (e.l == FS_NEG) || (e.r == FS_POS) || (e.r == FS_NEG);
        expQ.push_back(e);
      end
      mdlLValid = 1'b0;
    end
  endtask

  task automatic modelReset();
    mdlHunting = 1'b1;
    mdlPrimed  = 1'b0;
    mdlLValid  = 1'b0;
  endtask

  // Play one slot of len BCK periods for channel ch carrying word w (MSB first).
  task automatic applyStimulus(input logic ch, input logic [23:0] w, input int len);
    if (!mdlHunting) modelClose(prevCh, prevW, prevLen);
    else if (mdlPrimed && ch != mdlLastCh) mdlHunting = 1'b0;
    for (int j = 0; j < len; j++) begin
      logic d;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
      d = bitOf(w, j);
`else
      d = (j == 0) ? pendingBit : bitOf(w, j - 1);
`endif
      BCK = 1'b0;
      LRCK = ch;
      SData = d;
      repeat (halfPer) @(negedge Clock);
      BCK = 1'b1;
      if (j == 0) riseCycle = cycleCnt;
      repeat (halfPer) @(negedge Clock);
    end
    pendingBit = bitOf(w, len - 1);
    mdlPrimed = 1'b1;
    mdlLastCh = ch;
    prevCh    = ch;
    prevW     = w;
    prevLen   = len;
  endtask

  task automatic checkEvents(input string tag);
    int n;
    checkOutput({tag, " valid count"}, obsQ.size(), expQ.size());
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, " SampleL"}, obsQ[i].l, expQ[i].l);
      checkOutput({tag, " SampleR"}, obsQ[i].r, expQ[i].r);
      checkOutput({tag, " Clip"}, obsQ[i].clip, expQ[i].clip);
    end
    checkOutput({tag, " slot errors"}, obsErr, expErr);
    checkOutput({tag, " valid with error"}, bothCnt, 0);
    if (expQ.size() > 0) begin
      checkOutput({tag, " held SampleL"}, SampleL, expQ[expQ.size()-1].l);
      checkOutput({tag, " held SampleR"}, SampleR, expQ[expQ.size()-1].r);
    end
    expQ.delete();
    obsQ.delete();
    expErr = 0;
    obsErr = 0;
    bothCnt = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " SampleL"}, SampleL, 0);
    checkOutput({tag, " SampleR"}, SampleR, 0);
    checkOutput({tag, " Valid"}, Valid, 0);
    checkOutput({tag, " Clip"}, Clip, 0);
    checkOutput({tag, " SlotErr"}, SlotErr, 0);
  endtask

  // Directed and randomized stream scenarios, checked in sequence.
  initial begin
    logic [23:0] wA;
    logic [23:0] wB;
    logic [23:0] wC;
    logic [23:0] wD;
    int lenL;
    int lenR;

    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    checkResetOutputs("power-on reset");
    Reset = 1'b1;
    modelReset();
    @(negedge Clock);

    // 48 kHz, 64fs
    halfPer = 11;
    applyStimulus(CH_LEFT, 24'($urandom), 32);
    applyStimulus(CH_RIGHT, 24'($urandom), 32);
    applyStimulus(CH_LEFT, 24'h123456, 32);
    checkEvents("warmup");

    applyStimulus(CH_RIGHT, 24'hABCDEF, 32);
    applyStimulus(CH_LEFT, 24'h7FFF00, 32);
    checkEvents("basic");
    checkOutput("basic direct SampleL", SampleL, 16'h1234);
    checkOutput("basic direct SampleR", SampleR, 16'hABCD);
    checkOutput("basic direct Clip", Clip, 0);
    checkOutput("latency 48k", validCycle - riseCycle, SYNC_STAGES + 1);

    applyStimulus(CH_RIGHT, 24'h000000, 32);
    applyStimulus(CH_LEFT, 24'h000000, 32);
    checkEvents("clip positive");
    checkOutput("clip positive direct", Clip, 1);

    applyStimulus(CH_RIGHT, 24'h800000, 32);
    applyStimulus(CH_LEFT, 24'($urandom), 8);
    checkEvents("clip negative");
    checkOutput("clip negative direct SampleR", SampleR, 16'h8000);
    checkOutput("clip negative direct Clip", Clip, 1);

    wA = 24'($urandom);
    applyStimulus(CH_RIGHT, 24'($urandom), 32);
    applyStimulus(CH_LEFT, wA, 32);
    checkEvents("truncated slot");

    wB = 24'($urandom);
    applyStimulus(CH_RIGHT, wB, 32);
    applyStimulus(CH_LEFT, 24'($urandom), 32);
    checkEvents("recovery");
    checkOutput("recovery direct SampleL", SampleL, 32'(wA[23:8]));

    // Reset in the middle of a right slot
    applyStimulus(CH_RIGHT, 24'($urandom), 12);
    checkEvents("pre-reset");
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    checkResetOutputs("mid-slot reset");
    Reset = 1'b1;
    modelReset();
    wC = 24'($urandom);
    wD = 24'($urandom);
    applyStimulus(CH_RIGHT, 24'($urandom), 20);
    applyStimulus(CH_LEFT, wC, 32);
    applyStimulus(CH_RIGHT, wD, 32);
    applyStimulus(CH_LEFT, 24'($urandom), 32);
    checkEvents("post-reset");

    // 96 kHz, 64fs
    halfPer = 5;
    applyStimulus(CH_RIGHT, 24'($urandom), 32);
    applyStimulus(CH_LEFT, 24'($urandom), 32);
    checkEvents("96k");
    checkOutput("latency 96k", validCycle - riseCycle, SYNC_STAGES + 1);

    // 48 kHz, 32fs (16-bit slots)
    halfPer = 22;
    applyStimulus(CH_RIGHT, 24'($urandom), 16);
    applyStimulus(CH_LEFT, 24'($urandom), 16);
    applyStimulus(CH_RIGHT, 24'($urandom), 16);
    applyStimulus(CH_LEFT, 24'($urandom), 16);
    checkEvents("32fs");
    checkOutput("latency 32fs", validCycle - riseCycle, SYNC_STAGES + 1);

    // Randomized words and slot lengths, including occasional short slots
    halfPer = 11;
    for (int k = 0; k < 8; k++) begin
      lenR = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 15)) : int'($urandom_range(16, 32));
      lenL = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 15)) : int'($urandom_range(16, 32));
      applyStimulus(CH_RIGHT, 24'($urandom), lenR);
      applyStimulus(CH_LEFT, 24'($urandom), lenL);
      checkEvents("random");
    end

`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    applyStimulus(CH_RIGHT, 24'($urandom), 32);
    applyStimulus(CH_LEFT, 24'h800100, 32);
    applyStimulus(CH_RIGHT, 24'h000100, 32);
    applyStimulus(CH_LEFT, 24'($urandom), 32);
    checkEvents("left-justified");
    checkOutput("left-justified direct SampleL", SampleL, 16'h8001);
    checkOutput("left-justified direct SampleR", SampleR, 16'h0001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
